// File: rtl/screen_manager_if.sv
// rtl/screen_manager_if.sv - touch, app-control and framebuffer-mux signals of the screen manager
interface screen_manager_if #(
   parameter int NUM_APPS = 2
);
   logic                framebufferClk;
   logic                touch_valid;
   logic                touch_down;
   logic [8:0]          touch_gx;
   logic [8:0]          touch_gy;
   logic [NUM_APPS-1:0] app_exit_req;
   logic [2:0]          fb_sel;
   logic [NUM_APPS-1:0] app_run;
   logic [NUM_APPS-1:0] app_start;
   logic                app_touch_en;
   logic                home_press;
   logic [1:0]          home_press_idx;
   logic                frame_start;

   modport master (
      input  framebufferClk, touch_valid, touch_down, touch_gx, touch_gy, app_exit_req,
      output fb_sel, app_run, app_start, app_touch_en, home_press, home_press_idx, frame_start
   );

   modport slave (
      output framebufferClk, touch_valid, touch_down, touch_gx, touch_gy, app_exit_req,
      input  fb_sel, app_run, app_start, app_touch_en, home_press, home_press_idx, frame_start
   );
endinterface

// File: rtl/screen_manager.sv
// rtl/screen_manager.sv - home screen / app scheduler with frame-aligned framebuffer switching
// Optional long-press corner exit: SCREEN_MGR_LONGPRESS_EXIT_EN
module screen_manager #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int GAME_W      = 320,
   parameter int GAME_H      = 240,
   parameter int NUM_APPS    = 2,
   parameter int ICON_X0     = 256,
   parameter int ICON_STEP   = 64,
   parameter int ICON_Y0     = 16,
   parameter int ICON_W      = 48,
   parameter int ICON_H      = 48,
   parameter int HIT_MARGIN  = 4,
   parameter int HOLD_MS     = 1000
) (
   input  logic               clk_50,
   input  logic               reset_n,
   screen_manager_if.master   bus
);
   localparam logic [16:0] PIX_LAST = 17'(GAME_W * GAME_H - 1);
   localparam int          HOLD_CYC = CLK_FREQ_HZ / 1000 * HOLD_MS;

   typedef enum logic [2:0] {
      S_HOME     = 3'd0,
      S_ARM      = 3'd1,
      S_SWAP_IN  = 3'd2,
      S_RUN      = 3'd3,
      S_SWAP_OUT = 3'd4
   } state_t;

   state_t              state, state_nx;
   logic [16:0]         pix_cnt;
   logic                fb_prev, touch_prev;
   logic                lockout, lockout_nx, set_lock, bad_state;
   logic [1:0]          pend, pend_nx;
   logic [3:0]          hit;
   logic                tap_hit, exit_sel, long_exit;
   logic [1:0]          tap_idx;
   logic                wrap, touch_rise;
   int                  gx, gy;

   logic [2:0]          fb_sel_q, fb_sel_nx;
   logic [NUM_APPS-1:0] app_run_q, app_run_nx, app_start_q, app_start_nx, run_vec;
   logic                touch_en_q, touch_en_nx, press_q, press_nx, frame_start_q, frame_start_nx;
   logic [1:0]          press_idx_q, press_idx_nx;

   assign wrap       = bus.framebufferClk && !fb_prev && (pix_cnt == PIX_LAST);
   assign touch_rise = bus.touch_down && !touch_prev;
   assign gx         = {23'd0, bus.touch_gx};
   assign gy         = {23'd0, bus.touch_gy};

   // hitbox per slot, margin included on every side
   always_comb begin
      hit = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < NUM_APPS
             && gx >= ICON_X0 - k * ICON_STEP - HIT_MARGIN
             && gx <  ICON_X0 - k * ICON_STEP + ICON_W + HIT_MARGIN
             && gy >= ICON_Y0 - HIT_MARGIN
             && gy <  ICON_Y0 + ICON_H + HIT_MARGIN)
            hit[k] = 1'b1;
      end
   end

   always_comb begin
      tap_hit = 1'b0;
      tap_idx = 2'd0;
      for (int k = 3; k >= 0; k--) begin
         if (hit[k]) begin
            tap_hit = 1'b1;
            tap_idx = 2'(k);
         end
      end
   end

   always_comb begin
      exit_sel = 1'b0;
      for (int k = 0; k < NUM_APPS; k++)
         if (pend == 2'(k))
            exit_sel = bus.app_exit_req[k];
   end

`ifdef SCREEN_MGR_LONGPRESS_EXIT_EN
   localparam int HW = $clog2(HOLD_CYC + 1);
   logic [HW-1:0] hold_cnt;
   logic          in_corner;

   assign in_corner = bus.touch_valid && bus.touch_down && bus.touch_gx < 9'd32 && bus.touch_gy < 9'd32;
   assign long_exit = (state == S_RUN) && in_corner && (hold_cnt == HW'(HOLD_CYC - 1));

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n)
         hold_cnt <= '0;
      else if (state != S_RUN || !bus.touch_down || (bus.touch_valid && !in_corner) || long_exit)
         hold_cnt <= '0;
      else if (in_corner)
         hold_cnt <= hold_cnt + 1'b1;
   end
`else
   // without the corner gesture the hold time has no effect
   assign long_exit = 1'b0 && (HOLD_CYC != 0);
`endif

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state         <= S_HOME;
         pend          <= 2'd0;
         lockout       <= 1'b0;
         pix_cnt       <= '0;
         fb_prev       <= 1'b0;
         touch_prev    <= 1'b0;
         fb_sel_q      <= 3'd0;
         app_run_q     <= '0;
         app_start_q   <= '0;
         touch_en_q    <= 1'b0;
         press_q       <= 1'b0;
         press_idx_q   <= 2'd0;
         frame_start_q <= 1'b0;
      end else begin
         state         <= state_nx;
         pend          <= pend_nx;
         lockout       <= lockout_nx;
         fb_prev       <= bus.framebufferClk;
         touch_prev    <= bus.touch_down;
         if (bus.framebufferClk && !fb_prev)
            pix_cnt <= (pix_cnt == PIX_LAST) ? 17'd0 : pix_cnt + 17'd1;
         fb_sel_q      <= fb_sel_nx;
         app_run_q     <= app_run_nx;
         app_start_q   <= app_start_nx;
         touch_en_q    <= touch_en_nx;
         press_q       <= press_nx;
         press_idx_q   <= press_idx_nx;
         frame_start_q <= frame_start_nx;
      end
   end

   always_comb begin
      state_nx  = S_HOME;
      pend_nx   = pend;
      set_lock  = 1'b0;
      bad_state = 1'b0;
      case (state)
         S_HOME: begin
            if (touch_rise && bus.touch_valid && !lockout && tap_hit) begin
               state_nx = S_ARM;
               pend_nx  = tap_idx;
            end
         end
         S_ARM: begin
            if (!bus.touch_down)
               state_nx = S_SWAP_IN;
            else if (bus.touch_valid && !hit[pend])
               set_lock = 1'b1;
            else
               state_nx = S_ARM;
         end
         S_SWAP_IN:  state_nx = wrap ? S_RUN : S_SWAP_IN;
         S_RUN: begin
            if (exit_sel || long_exit) begin
               state_nx = S_SWAP_OUT;
               set_lock = long_exit;
            end else begin
               state_nx = S_RUN;
            end
         end
         S_SWAP_OUT: begin
            if (wrap)
               set_lock = 1'b1;
            else
               state_nx = S_SWAP_OUT;
         end
         default: begin
            pend_nx   = 2'd0;
            bad_state = 1'b1;
         end
      endcase
      // lockout only survives while the finger stays down
      lockout_nx = bus.touch_down && (set_lock || (lockout && !bad_state));
   end

   always_comb begin
      frame_start_nx = wrap && !bad_state;
      fb_sel_nx      = 3'd0;
      app_run_nx     = '0;
      app_start_nx   = '0;
      touch_en_nx    = 1'b0;
      press_nx       = 1'b0;
      press_idx_nx   = 2'd0;
      for (int k = 0; k < NUM_APPS; k++)
         run_vec[k] = (pend_nx == 2'(k));
      case (state_nx)
         S_ARM: begin
            press_nx     = 1'b1;
            press_idx_nx = pend_nx;
         end
         S_RUN: begin
            fb_sel_nx   = 3'(pend_nx) + 3'd1;
            app_run_nx  = run_vec;
            touch_en_nx = !lockout_nx;
         end
         S_SWAP_OUT: fb_sel_nx = 3'(pend_nx) + 3'd1;
         default: ;
      endcase
      if (state == S_SWAP_IN && wrap)
         app_start_nx = run_vec;
   end

   assign bus.fb_sel         = fb_sel_q;
   assign bus.app_run        = app_run_q;
   assign bus.app_start      = app_start_q;
   assign bus.app_touch_en   = touch_en_q;
   assign bus.home_press     = press_q;
   assign bus.home_press_idx = press_idx_q;
   assign bus.frame_start    = frame_start_q;
endmodule

// File: tb/tb_screen_manager.sv
// tb/tb_screen_manager.sv - randomized directed bench for screen_manager against a frame/hitbox model
module tb_screen_manager;
   localparam int NUM_APPS    = 2;
   localparam int GAME_W      = 32;
   localparam int GAME_H      = 16;
   localparam int FRAME       = GAME_W * GAME_H;
   localparam int CLK_FREQ_HZ = 10_000;
   localparam int HOLD_MS     = 100;
   localparam int HOLD_CYC    = CLK_FREQ_HZ / 1000 * HOLD_MS;
   localparam int ICON_X0 = 256, ICON_STEP = 64, ICON_Y0 = 16, ICON_W = 48, ICON_H = 48, HIT_MARGIN = 4;

   logic clk_50 = 1'b0;
   logic reset_n = 1'b0;
   always #10 clk_50 = ~clk_50;

   screen_manager_if #(.NUM_APPS(NUM_APPS)) bus ();

   screen_manager #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ), .GAME_W(GAME_W), .GAME_H(GAME_H), .NUM_APPS(NUM_APPS),
      .ICON_X0(ICON_X0), .ICON_STEP(ICON_STEP), .ICON_Y0(ICON_Y0), .ICON_W(ICON_W),
      .ICON_H(ICON_H), .HIT_MARGIN(HIT_MARGIN), .HOLD_MS(HOLD_MS)
   ) dut (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;
   int m_pix, frames;
   bit m_fb, m_wrap;
   int x, y, k;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int icon_at(input int px, input int py);
      for (int i = 0; i < NUM_APPS; i++) begin
         int x0;
         x0 = ICON_X0 - i * ICON_STEP;
         if (px >= x0 - HIT_MARGIN && px <= x0 + ICON_W - 1 + HIT_MARGIN &&
             py >= ICON_Y0 - HIT_MARGIN && py <= ICON_Y0 + ICON_H - 1 + HIT_MARGIN)
            return i;
      end
      return -1;
   endfunction

   // one clock; the model counts strobe rising edges and knows when a frame wraps
   task automatic cyc(input bit s);
      logic [2:0] prev_sel;
      bit         rise;
      prev_sel = bus.fb_sel;
      bus.framebufferClk = s;
      @(posedge clk_50);
      #1;
      rise   = s && !m_fb;
      m_fb   = s;
      m_wrap = rise && (m_pix == FRAME - 1);
      if (rise) m_pix = (m_pix + 1) % FRAME;
      if (m_wrap) frames++;
      check("frame_start", bus.frame_start, m_wrap);
      if (!m_wrap) begin
         check("fb_sel_only_at_wrap", bus.fb_sel, prev_sel);
         check("start_only_at_wrap", bus.app_start, 0);
      end
   endtask

   task automatic idle();
      cyc(m_fb);
   endtask

   task automatic rnd();
      cyc(1'($urandom_range(0, 1)));
   endtask

   task automatic wait_wrap(input string tag);
      int n;
      n = 0;
      do begin
         rnd();
         n++;
      end while (!m_wrap && n < 16 * FRAME);
      check(tag, m_wrap, 1);
   endtask

   // leave the strobe low with the counter on its last pixel: the next cyc(1) wraps
   task automatic goto_last();
      int n;
      n = 0;
      while (m_pix != FRAME - 1 && n < 16 * FRAME) begin
         rnd();
         n++;
      end
      cyc(1'b0);
   endtask

   task automatic touch(input bit down, input int px, input int py);
      bus.touch_valid = 1'b1;
      bus.touch_down  = down;
      bus.touch_gx    = 9'(px);
      bus.touch_gy    = 9'(py);
   endtask

   task automatic launch(input int slot, input int px, input int py);
      touch(1'b1, px, py);
      idle();
      check("launch_press", bus.home_press, 1);
      check("launch_idx", bus.home_press_idx, slot);
      touch(1'b0, px, py);
      idle();
      check("launch_wait_fb", bus.fb_sel, 0);
      wait_wrap("launch_wrap");
      check("launch_fb_sel", bus.fb_sel, slot + 1);
      check("launch_start", bus.app_start, 1 << slot);
      check("launch_run", bus.app_run, 1 << slot);
      check("launch_touch_en", bus.app_touch_en, 1);
      idle();
      check("launch_start_pulse", bus.app_start, 0);
   endtask

   initial begin
      bus.framebufferClk = 1'b0;
      bus.touch_valid    = 1'b0;
      bus.touch_down     = 1'b0;
      bus.touch_gx       = 9'd0;
      bus.touch_gy       = 9'd0;
      bus.app_exit_req   = '0;
      m_pix = 0; m_fb = 1'b0; m_wrap = 1'b0; frames = 0;

      repeat (3) @(posedge clk_50);
      #1;
      check("rst_fb_sel", bus.fb_sel, 0);
      check("rst_app_run", bus.app_run, 0);
      check("rst_app_start", bus.app_start, 0);
      check("rst_touch_en", bus.app_touch_en, 0);
      check("rst_press", bus.home_press, 0);
      check("rst_press_idx", bus.home_press_idx, 0);
      check("rst_frame_start", bus.frame_start, 0);
      check("rst_pix_cnt", dut.pix_cnt, 0);
      reset_n = 1'b1;

      for (int i = 0; i < FRAME; i++) begin
         cyc(1'b1);
         cyc(1'b0);
      end
      check("frame_count", frames, 1);
      check("pix_cnt_wrapped", dut.pix_cnt, 0);
      check("frame_fb_sel", bus.fb_sel, 0);

      // random presses, each cancelled by sliding away so nothing launches
      for (int i = 0; i < 12; i++) begin
         if (i % 2 == 0) begin
            x = $urandom_range(ICON_X0 - (i / 2 % NUM_APPS) * ICON_STEP - HIT_MARGIN,
                               ICON_X0 - (i / 2 % NUM_APPS) * ICON_STEP + ICON_W + HIT_MARGIN);
            y = $urandom_range(ICON_Y0 - HIT_MARGIN - 2, ICON_Y0 + ICON_H + HIT_MARGIN + 1);
         end else begin
            x = $urandom_range(0, 319);
            y = $urandom_range(0, 90);
         end
         k = icon_at(x, y);
         touch(1'b1, x, y);
         idle();
         check("rand_press", bus.home_press, k >= 0);
         check("rand_idx", bus.home_press_idx, (k >= 0) ? k : 0);
         touch(1'b1, 100, 200);
         idle();
         check("rand_cancel", bus.home_press, 0);
         touch(1'b0, 100, 200);
         idle();
         idle();
         check("rand_no_launch", bus.app_run, 0);
      end

      touch(1'b1, 280, 40);
      idle();
      check("slide_press", bus.home_press, 1);
      touch(1'b1, 100, 200);
      idle();
      check("slide_cancel", bus.home_press, 0);
      touch(1'b1, 280, 40);
      idle();
      check("slide_no_rearm", bus.home_press, 0);
      touch(1'b0, 280, 40);
      idle();
      wait_wrap("slide_wrap");
      check("slide_fb_sel", bus.fb_sel, 0);
      check("slide_run", bus.app_run, 0);

      launch(0, 280, 40);
      bus.app_exit_req = 2'b10;
      idle();
      check("foreign_exit_ignored", bus.app_run, 2'b01);
      bus.app_exit_req = 2'b01;
      idle();
      bus.app_exit_req = 2'b00;
      check("exit_run_low", bus.app_run, 0);
      check("exit_touch_en", bus.app_touch_en, 0);
      check("exit_fb_kept", bus.fb_sel, 1);
      wait_wrap("exit_wrap");
      check("exit_home", bus.fb_sel, 0);

      x = $urandom_range(ICON_X0 - ICON_STEP - HIT_MARGIN, ICON_X0 - ICON_STEP + ICON_W - 1 + HIT_MARGIN);
      y = $urandom_range(ICON_Y0, ICON_Y0 + ICON_H - 1);
      touch(1'b1, x, y);
      idle();
      check("app1_idx", bus.home_press_idx, 1);
      goto_last();
      touch(1'b0, x, y);
      cyc(1'b1);
      check("release_at_wrap_fb", bus.fb_sel, 0);
      check("release_at_wrap_start", bus.app_start, 0);
      wait_wrap("app1_wrap");
      check("app1_fb_sel", bus.fb_sel, 2);
      check("app1_start", bus.app_start, 2'b10);
      check("app1_run", bus.app_run, 2'b10);
      idle();
      check("app1_start_pulse", bus.app_start, 0);

      goto_last();
      bus.app_exit_req = 2'b10;
      cyc(1'b1);
      bus.app_exit_req = 2'b00;
      check("exit_at_wrap_run", bus.app_run, 0);
      check("exit_at_wrap_fb", bus.fb_sel, 2);
      wait_wrap("exit_at_wrap_next");
      check("exit_at_wrap_home", bus.fb_sel, 0);

      launch(0, 280, 40);
      touch(1'b1, 10, 10);
      repeat (HOLD_CYC + 20) idle();
`ifdef SCREEN_MGR_LONGPRESS_EXIT_EN
      check("hold_exit_run", bus.app_run, 0);
      check("hold_lockout", bus.app_touch_en, 0);
      touch(1'b0, 10, 10);
      wait_wrap("hold_wrap");
      check("hold_home", bus.fb_sel, 0);
`else
      check("hold_no_exit", bus.app_run, 2'b01);
      check("hold_touch_en", bus.app_touch_en, 1);
      touch(1'b0, 10, 10);
      idle();
      bus.app_exit_req = 2'b01;
      idle();
      bus.app_exit_req = 2'b00;
      check("hold_manual_exit", bus.app_run, 0);
      wait_wrap("hold_wrap");
      check("hold_home", bus.fb_sel, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/screen_manager.md
# screen_manager

Display/app scheduler between the ILI9341 driver, the FT6336 touch path and up to four app renderers (Breakout and future apps). It owns the home screen: hit-tests taps against the app icon row, launches and retires apps, and gates touch forwarding. It switches the framebuffer source only on a frame boundary so the panel never shows a torn mix of two renderers.

## Interface
- CLK_FREQ_HZ, 50_000_000, clk_50 frequency (long-press timing)
- GAME_W, 320, frame width in pixels
- GAME_H, 240, frame height in pixels
- NUM_APPS, 2, app slots, legal 1..4
- ICON_X0, 256, left x of app 0 icon; app k icon at ICON_X0 − k·ICON_STEP
- ICON_STEP, 64, horizontal icon pitch
- ICON_Y0, 16, top y of all icons
- ICON_W / ICON_H, 48 / 48, icon size
- HIT_MARGIN, 4, extra hitbox on every icon side
- HOLD_MS, 1000, long-press exit hold time

- clk_50  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- framebufferClk  in  1  pixel-fetch strobe from tft_ili9341, sampled in clk_50; each rising edge consumes one pixel
- touch_valid  in  1  touch sample qualifier
- touch_down  in  1  finger present
- touch_gx  in  9  touch x in game coordinates, 0..319
- touch_gy  in  9  touch y in game coordinates, 0..239
- app_exit_req  in  NUM_APPS  level quit request from each app
- fb_sel  out  3  framebuffer mux select: 0 = home, 1+k = app k
- app_run  out  NUM_APPS  one-hot run enable
- app_start  out  NUM_APPS  one-cycle new-game pulse
- app_touch_en  out  1  forward touches to the running app
- home_press  out  1  icon currently pressed (highlight)
- home_press_idx  out  2  index of pressed icon
- frame_start  out  1  one-cycle pulse at each frame wrap

## Operation
- Pixel counter pix_cnt, 17 bits, increments on each framebufferClk rising edge; wraps GAME_W·GAME_H−1 → 0. wrap = that edge while pix_cnt = 76799.
- touch_rise = touch_down high, previous sample low. Coordinates are used only when touch_valid = 1.
- lockout flag: set on cancel or on return to home while touch_down = 1; cleared when touch_down = 0. While set, taps are ignored and app_touch_en = 0.
- States:
  - S_HOME: touch_rise and touch_valid, lockout clear, and point inside icon k with margin (k < NUM_APPS; lowest k wins on overlap) → S_ARM, pend = k.
  - S_ARM: home_press = 1, home_press_idx = pend. touch_down = 0 → S_SWAP_IN. Valid point outside icon pend while down → S_HOME, lockout set.
  - S_SWAP_IN: on wrap, fb_sel ← 1+pend, app_start[pend] pulse, app_run[pend] ← 1 → S_RUN.
  - S_RUN: app_touch_en = ¬lockout. app_exit_req[pend] = 1 → app_run ← 0, app_touch_en ← 0 → S_SWAP_OUT. Exit requests from other slots are ignored.
  - S_SWAP_OUT: on wrap, fb_sel ← 0 → S_HOME; lockout ← touch_down.
- Unused state encodings → S_HOME, with all outputs at reset values.

## Timing
- Reset: fb_sel = 0, app_run = 0, app_start = 0, app_touch_en = 0, home_press = 0, home_press_idx = 0, frame_start = 0, pix_cnt = 0, lockout = 0, state S_HOME. The tft driver resets from the same reset_n, so pixel alignment holds.
- All outputs are registered. frame_start, the fb_sel change and app_start appear in the cycle after the clk_50 edge that samples the wrap strobe edge, all in the same cycle.
- Exit request to app_run low: 1 cycle. Return to home: at the next wrap, never earlier.
- exit_req and wrap in the same cycle in S_RUN: go to S_SWAP_OUT; the swap waits for the following wrap.
- Release in S_ARM on the same cycle as wrap: go to S_SWAP_IN; the swap happens at the next wrap.
- Reset mid-swap: immediate return to reset values.

## Configuration
- SCREEN_MGR_LONGPRESS_EXIT_EN defined: in S_RUN, a valid touch held continuously inside x < 32, y < 32 for HOLD_MS·CLK_FREQ_HZ/1000 cycles acts as app_exit_req[pend]. Lifting the finger or leaving the corner clears the counter. Lockout is set on exit.
- Not defined: there is no hold counter, and exit happens only via app_exit_req.

## Test plan
- Reset, then drive 76800 strobes → frame_start pulses exactly once; pix_cnt returns to 0; fb_sel = 0.
- Tap at (280,40), down then up, in S_HOME → home_press_idx = 0 while down. At the next wrap: fb_sel = 1, app_start[0] one cycle, app_run = 01.
- Press at (280,40), slide to (100,200), release → back to S_HOME with no launch. A new tap is accepted only after touch_down = 0.
- In S_RUN, assert app_exit_req[0] mid-frame → app_run = 0 next cycle; fb_sel stays 1 until the wrap, then 0.
- With NUM_APPS = 2, tap at (216,40) → app 1 launches (fb_sel = 2). With NUM_APPS = 1 the same tap is ignored.
- With the macro defined, hold (10,10) for HOLD_MS → exit, and lockout holds app_touch_en = 0 until release. Without the macro, the same hold does nothing.
